// File: rtl/i281_run_controller_if.sv
// Board/CPU-side signal bundle for the i281 run/step sequencer.
// slave = the controller itself; master = the board switches plus the CPU datapath/FSM.
interface i281_run_controller_if #(
  parameter int PC_W = 6
);
  logic            run_sw;
  logic            step_btn;
  logic            step_mode;
  logic            bp_en;
  logic [PC_W-1:0] bp_addr;
  logic [PC_W-1:0] pc;
  logic            at_if;
  logic            perf_clr;
  logic            cpu_en;
  logic            halted;
  logic            bp_hit;
  logic [2:0]      ctrl_state;
  logic [31:0]     cycle_cnt;
  logic [31:0]     instr_cnt;

  modport slave (
    input  run_sw, step_btn, step_mode, bp_en, bp_addr, pc, at_if, perf_clr,
    output cpu_en, halted, bp_hit, ctrl_state, cycle_cnt, instr_cnt
  );

  modport master (
    output run_sw, step_btn, step_mode, bp_en, bp_addr, pc, at_if, perf_clr,
    input  cpu_en, halted, bp_hit, ctrl_state, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/i281_run_controller.sv
// i281 run/step sequencer: produces cpu_en for free run, cycle step, instruction step and PC breakpoint.
// Optional performance counters are built only when RUN_CTRL_PERF_EN is defined.
module i281_run_controller #(
  parameter int PC_W    = 6,
  parameter int RUN_DIV = 1
) (
  input logic                  clock,
  input logic                  reset,
  i281_run_controller_if.slave io_bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_STEP_C = 3'd2;
  localparam logic [2:0] S_STEP_I = 3'd3;
  localparam logic [2:0] S_BREAK  = 3'd4;

  localparam logic [15:0] DIV_LAST = 16'(RUN_DIV - 1);

  logic [1:0]      r_runSync;
  logic [1:0]      r_stepSync;
  logic            r_stepDly;
  logic            r_stepEdge;
  logic [15:0]     r_div;
  logic [2:0]      r_state;
  logic            r_bpSkip;
  logic            r_first;

  logic            w_runS;
  logic            w_tick;
  logic            w_bpMatch;
  logic [PC_W-1:0] w_pc;
  logic [PC_W-1:0] w_bpAddr;
  logic [2:0]      w_nextState;
  logic            w_cpuEn;
  logic            w_setSkip;
  logic            w_clrSkip;

  assign w_runS   = r_runSync[1];
  assign w_tick   = (r_div == DIV_LAST);
  assign w_pc     = io_bus.pc;
  assign w_bpAddr = io_bus.bp_addr;
  assign w_bpMatch = io_bus.at_if & io_bus.bp_en & (w_pc == w_bpAddr) & ~r_bpSkip;

  // Switch and button are asynchronous; the step edge is registered once more after sync.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_runSync  <= 2'b00;
      r_stepSync <= 2'b00;
      r_stepDly  <= 1'b0;
      r_stepEdge <= 1'b0;
    end else begin
      r_runSync  <= {r_runSync[0], io_bus.run_sw};
      r_stepSync <= {r_stepSync[0], io_bus.step_btn};
      r_stepDly  <= r_stepSync[1];
      r_stepEdge <= r_stepSync[1] & ~r_stepDly;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div <= 16'd0;
    end else if (r_state == S_RUN) begin
      r_div <= w_tick ? 16'd0 : r_div + 16'd1;
    end else begin
      r_div <= 16'd0;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_cpuEn     = 1'b0;
    w_setSkip   = 1'b0;
    w_clrSkip   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_runS) begin
          w_nextState = S_RUN;
          w_setSkip   = 1'b1;
        end else if (r_stepEdge) begin
          w_nextState = io_bus.step_mode ? S_STEP_I : S_STEP_C;
        end
      end
      S_STEP_C: begin
        w_cpuEn     = 1'b1;
        w_nextState = S_IDLE;
      end
      S_STEP_I: begin
        if (~r_first & io_bus.at_if) begin
          w_nextState = S_IDLE;
        end else begin
          w_cpuEn = 1'b1;
        end
      end
      // Stopping only at an IF boundary lets a dropped run finish the current instruction.
      S_RUN: begin
        if (w_tick) begin
          if (w_bpMatch) begin
            w_nextState = S_BREAK;
          end else if (~w_runS & io_bus.at_if) begin
            w_nextState = S_IDLE;
          end else begin
            w_cpuEn   = 1'b1;
            w_clrSkip = 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (~w_runS) begin
          w_nextState = S_IDLE;
        end else if (r_stepEdge) begin
          w_nextState = io_bus.step_mode ? S_STEP_I : S_STEP_C;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_bpSkip <= 1'b0;
      r_first  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_first <= (w_nextState == S_STEP_I) && (r_state != S_STEP_I);
      if (w_setSkip) begin
        r_bpSkip <= 1'b1;
      end else if (w_clrSkip) begin
        r_bpSkip <= 1'b0;
      end
    end
  end

  assign io_bus.cpu_en     = w_cpuEn;
  assign io_bus.halted     = (r_state == S_IDLE) | (r_state == S_BREAK);
  assign io_bus.bp_hit     = (r_state == S_BREAK);
  assign io_bus.ctrl_state = r_state;

`ifdef RUN_CTRL_PERF_EN
  logic [31:0] r_cycleCnt;
  logic [31:0] r_instrCnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycleCnt <= 32'd0;
      r_instrCnt <= 32'd0;
    end else if (io_bus.perf_clr) begin
      r_cycleCnt <= 32'd0;
      r_instrCnt <= 32'd0;
    end else if (w_cpuEn) begin
      r_cycleCnt <= r_cycleCnt + 32'd1;
      if (io_bus.at_if) begin
        r_instrCnt <= r_instrCnt + 32'd1;
      end
    end
  end

  assign io_bus.cycle_cnt = r_cycleCnt;
  assign io_bus.instr_cnt = r_instrCnt;
`else
  logic w_unusedPerfClr;

  assign w_unusedPerfClr  = io_bus.perf_clr;
  assign io_bus.cycle_cnt = 32'd0;
  assign io_bus.instr_cnt = 32'd0;
`endif

endmodule

// File: doc/i281_run_controller.md
Name: i281_run_controller

Overview:
- Run/step sequencer for the i281 multicycle CPU.
- Generates the single clock-enable (cpu_en) that gates the control FSM state register, PC, register file and flag register writes.
- Supports free run with a rate divider, single-cycle step, single-instruction step and one PC breakpoint.
- Sits between the board switches/buttons and the multicycle control FSM; uses the FSM's "in IF" indication as the instruction boundary.

Parameters:
- PC_W, 6: width of PC and breakpoint address.
- RUN_DIV, 1: free-run rate; cpu_en asserted once every RUN_DIV cycles; legal range 1..65535.

Ports:
- clock  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- run_sw  input  1  run switch; asynchronous level.
- step_btn  input  1  step button; asynchronous, debounced externally.
- step_mode  input  1  0 = cycle step, 1 = instruction step.
- bp_en  input  1  breakpoint enable.
- bp_addr  input  PC_W  breakpoint PC.
- pc  input  PC_W  current PC from datapath.
- at_if  input  1  control FSM currently in IF state (next enabled cycle starts a fetch).
- perf_clr  input  1  synchronous clear of performance counters.
- cpu_en  output  1  CPU advance enable.
- halted  output  1  CPU stopped (IDLE or BREAK).
- bp_hit  output  1  stopped on breakpoint.
- ctrl_state  output  3  current state encoding.
- cycle_cnt  output  32  enabled-cycle count.
- instr_cnt  output  32  fetched-instruction count.

Behaviour:
- Input conditioning:
  - run_sw and step_btn each pass through a 2-flop synchronizer.
  - step_edge = rising edge of the synchronized step, registered once.
  - step_btn rising at edge t gives step_edge high during cycle t+2 and the new state at t+3.
- Divider: counter 0..RUN_DIV-1; tick when the count is RUN_DIV-1 (tick always 1 when RUN_DIV=1). The counter runs only in RUN and is cleared in every other state.
- States: IDLE=0, RUN=1, STEP_C=2, STEP_I=3, BREAK=4. Other encodings go to IDLE.
- IDLE:
  - cpu_en=0.
  - run_s=1 -> RUN, and set bp_skip.
  - Otherwise step_edge -> STEP_C (step_mode=0) or STEP_I (step_mode=1).
  - run has priority over step.
- STEP_C: cpu_en=1 for exactly one cycle, then -> IDLE.
- STEP_I:
  - first-cycle flag set on entry.
  - cpu_en = first | ~at_if.
  - When ~first & at_if: cpu_en=0, -> IDLE.
  - Exactly one full instruction executes, including 2-cycle NOOP/CMP and 4-cycle LOAD.
- RUN: all decisions are evaluated only on tick cycles; cpu_en=0 on non-tick cycles.
  - Breakpoint: at_if & bp_en & (pc==bp_addr) & ~bp_skip -> BREAK, cpu_en=0 that cycle.
  - Else run_s=0 & at_if -> IDLE, cpu_en=0.
  - Else cpu_en=1. Dropping run mid-instruction completes the current instruction before stopping.
  - bp_skip clears on the first cpu_en=1 cycle in RUN.
- BREAK:
  - cpu_en=0, bp_hit=1.
  - run_s=0 -> IDLE.
  - Else step_edge -> STEP_C/STEP_I (bp_hit clears).
  - run_s held high stays in BREAK; resuming requires run low then high. This re-enters RUN with bp_skip set, so the breakpoint instruction executes without re-hitting.
- Outputs:
  - halted = (state==IDLE) | (state==BREAK).
  - bp_hit = (state==BREAK).
  - ctrl_state = state.
  - cpu_en is combinational from registered state, divider, bp_skip, at_if and pc only; there is no combinational path from run_sw or step_btn.
- Reset (any time, including mid-instruction): state=IDLE, cpu_en=0, halted=1, bp_hit=0, synchronizers/edge/divider/bp_skip/first=0, counters=0. The CPU is reset by the same signal.

Optional Feature:
- RUN_CTRL_PERF_EN defined:
  - cycle_cnt increments on every cpu_en=1 cycle.
  - instr_cnt increments on cpu_en & at_if.
  - Both wrap at 2^32 and are cleared by reset or perf_clr. perf_clr has priority over increment in the same cycle.
- Undefined: cycle_cnt and instr_cnt tied to 0, no counter flops; ports remain.

Test Plan:
- Reset, step_mode=0, step_btn pulse at edge t -> cpu_en=1 only in cycle t+3; halted=0 in that cycle; back to IDLE, halted=1.
- step_mode=1, at_if=1 then 0,0,0, then 1 (LOAD) -> cpu_en high exactly 4 cycles, then 0; ctrl_state returns to 0.
- RUN_DIV=4, run_sw=1 held 40 cycles -> cpu_en high once every 4 cycles (10 pulses ±1 at start).
- bp_en=1, bp_addr=6'h05, run, pc reaches 5 with at_if=1 -> cpu_en=0, bp_hit=1, ctrl_state=4; run low then high -> instruction at PC 5 executes, no re-break until pc==5 & at_if again.
- run_sw dropped while at_if=0 in the middle of an instruction -> cpu_en stays 1 until at_if=1, then 0, halted=1.
- Reset asserted mid-RUN -> cpu_en=0 and halted=1 immediately (asynchronously); with RUN_CTRL_PERF_EN, cycle_cnt=instr_cnt=0.
